// File: rtl/apb_pkg.sv
// Shared APB constants and the completer FSM state type, common to the bridge and its slaves.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Storage array behind the wait-state slave: async clear, single write port, combinational read.
module apb_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_wait_state_slave.sv
// APB completer with a programmable number of PREADY-low access cycles and PSLVERR on
// out-of-range addresses.
module apb_wait_state_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_W,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  apb_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;

  logic                  setup;
  logic                  access;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_err;
  logic [DATA_WIDTH-1:0] lookup_rdata;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic                  rf_we;

  // Full-width compare so an address that aliases a valid index is still rejected.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) >= 64'(MEM_DEPTH);
  endfunction

  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;

  // With zero wait states READY is entered straight from the setup cycle, before the
  // latched copy of the address exists, so the live bus address is looked up instead.
  assign lookup_addr  = (state == IDLE) ? PADDR : addr_q;
  assign lookup_err   = addr_err(lookup_addr);
  assign lookup_rdata = lookup_err ? '0 : rf_rdata;

  assign rf_we = (state == READY) & access & write_q & ~PSLVERR;

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (rf_we),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .raddr (lookup_addr[IDX_W-1:0]),
    .rdata (rf_rdata)
  );

  // Transfer attributes captured in the setup cycle; no reset needed on pure data.
  always_ff @(posedge PCLK) begin
    if ((state == IDLE) && setup) begin
      addr_q  <= PADDR;
      wdata_q <= PWDATA;
      write_q <= PWRITE;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            cnt <= CNT_LOAD;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
            end else begin
              state   <= READY;
              PREADY  <= 1'b1;
              PSLVERR <= lookup_err;
              if (!PWRITE) PRDATA <= lookup_rdata;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (cnt == CNT_ONE) begin
              state   <= READY;
              PREADY  <= 1'b1;
              PSLVERR <= lookup_err;
              if (!write_q) PRDATA <= lookup_rdata;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        READY: begin
          // Completion and abort both drop the response; only completion writes memory.
          if (!PSEL || PENABLE) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_wait_state_slave.sv
// Scoreboard bench for apb_wait_state_slave: a 2-wait-state and a 0-wait-state instance share one bus.
module tb_apb_wait_state_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata2, prdata0;
  logic       pready2, pslverr2, pready0, pslverr0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    bit         err;
    int         waits;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [64];
  bit         use0;

  always #5 clk = ~clk;

  apb_wait_state_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(2)
  ) dut (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
  );

  apb_wait_state_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(0)
  ) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input bit wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.rd    = !wr;
    e.err   = (addr >= 8'd64);
    e.waits = use0 ? 0 : 2;
    e.data  = (e.rd && !e.err) ? model[addr[5:0]] : 8'h00;
    if (wr && !e.err) model[addr[5:0]] = data;
    sb.push_back(e);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Starts at posedge+1; leaves the bus idle at posedge+1 right after completion.
  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          input string tag);
    exp_t e;
    int   waits;
    bit   rdy;
    push_exp(wr, addr, data);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    rdy   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdy = use0 ? pready0 : pready2;
      if (rdy) break;
      waits++;
    end
    e = sb.pop_front();
    if (!rdy) begin
      check_eq({tag, "_timeout"}, 32'(rdy), 32'(1));
    end else begin
      check_eq({tag, "_waits"}, 32'(waits), 32'(e.waits));
      check_eq({tag, "_pslverr"}, 32'(use0 ? pslverr0 : pslverr2), 32'(e.err));
      if (e.rd) check_eq({tag, "_prdata"}, 32'(use0 ? prdata0 : prdata2), 32'(e.data));
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    use0 = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pready", 32'(pready2), 32'(0));
    check_eq("rst_pslverr", 32'(pslverr2), 32'(0));
    check_eq("rst_prdata", 32'(prdata2), 32'(0));
    check_eq("rst_pready0", 32'(pready0), 32'(0));
    rst_n = 1'b1;
    idle_cycle();

    apb_xfer(1'b0, 8'h05, 8'h00, "t1_rd05");
    idle_cycle();

    apb_xfer(1'b1, 8'h10, 8'hA5, "t2_wr10");
    idle_cycle();
    apb_xfer(1'b0, 8'h10, 8'h00, "t2_rd10");
    idle_cycle();

    // 0x50 aliases index 0x10 in the low bits; the error write must not reach it.
    apb_xfer(1'b1, 8'h50, 8'h77, "t3_wr50");
    idle_cycle();
    apb_xfer(1'b0, 8'h50, 8'h00, "t3_rd50");
    idle_cycle();
    apb_xfer(1'b0, 8'h10, 8'h00, "t3_rd10");
    idle_cycle();

    apb_xfer(1'b1, 8'h3F, 8'h11, "t4_wr3f");
    apb_xfer(1'b0, 8'h3F, 8'h00, "t4_rd3f");
    idle_cycle();

    // Abort a write by dropping PSEL in the first access cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("t5_wait1_pready", 32'(pready2), 32'(0));
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_eq("t5_abort_pready", 32'(pready2), 32'(0));
    check_eq("t5_abort_pslverr", 32'(pslverr2), 32'(0));
    @(posedge clk); #1;
    apb_xfer(1'b0, 8'h20, 8'h00, "t5_rd20");
    idle_cycle();

    apb_xfer(1'b0, 8'h3F, 8'h00, "t6_rd3f");
    idle_cycle();

    // Reset asserted in a wait cycle while PRDATA still holds 0x11.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("t6_wait_pready", 32'(pready2), 32'(0));
    check_eq("t6_hold_prdata", 32'(prdata2), 32'h11);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pready", 32'(pready2), 32'(0));
    check_eq("t6_rst_pslverr", 32'(pslverr2), 32'(0));
    check_eq("t6_rst_prdata", 32'(prdata2), 32'(0));
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    idle_cycle();
    apb_xfer(1'b0, 8'h10, 8'h00, "t6_rd10_cleared");
    idle_cycle();

    use0 = 1'b1;
    apb_xfer(1'b1, 8'h03, 8'h5A, "t7_wr03");
    idle_cycle();
    apb_xfer(1'b0, 8'h03, 8'h00, "t7_rd03");
    apb_xfer(1'b0, 8'h45, 8'h00, "t7_rd45_err");
    idle_cycle();

    check_eq("sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
